counter_scan_ctrl: RTL and testbench
====================================

Name: counter_scan_ctrl

Overview:
Parametrised single-clock loadable up/down counter with a multiplexed seven-segment scan driver. It replaces derived slow clocks with clock-enable ticks from internal prescalers. It adds runtime hex/BCD mode, a direction toggle, a wrap flag and configurable digit count. It sits between the debounced switch/button inputs and the board's seven-segment display.

Parameters:
DIGITS, 4, number of display digits; counter width W = 4*DIGITS
COUNT_DIV, 100_000_000, clk cycles per count tick (1 Hz at 100 MHz)
SCAN_DIV, 100_000, clk cycles per digit-scan step (1 kHz)

Ports:
clk  in  1  system clock, 100 MHz
clr_n  in  1  reset, asynchronous, active-low
data  in  W  parallel load value from switches
load  in  1  load request, level, externally debounced
choose  in  1  direction toggle button, level, externally debounced
enable  in  1  count enable, level
bcd  in  1  1 = BCD mode, 0 = hex mode
q  out  W  current count
dir  out  1  0 = up, 1 = down
wrap  out  1  one-cycle pulse on wrap-around
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
scan  out  DIGITS  digit anodes, active-low one-hot

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low on clr_n. While clr_n=0:
  - q=0, dir=0, wrap=0
  - scan = all ones (display off), seg = 7'h7F (blank)
  - digit index = 0, both prescalers = 0, all synchroniser flops = 0
- Input synchronisation:
  - load, choose, enable and bcd each pass through a 2-FF synchroniser.
  - load and choose are rising-edge detected on the synchronised value. Each edge gives one 1-cycle pulse: load_p, choose_p.
- count_tick: asserts for 1 cycle when the count prescaler reaches COUNT_DIV-1, then the prescaler returns to 0.
- scan_tick: same scheme with SCAN_DIV.
- Count update, evaluated in this priority order:
  1. load_p:
     - q <= data; in BCD mode each nibble >9 is clamped to 9.
     - Count prescaler cleared, so the first count after a load comes a full COUNT_DIV later.
     - Any count_tick in the same cycle is discarded.
  2. count_tick with enable=1: q steps by ±1 per dir.
     - Hex mode: modulo 2^W.
     - BCD mode: per-digit decimal carry/borrow.
  3. Otherwise q holds. The prescaler runs regardless of enable.
- Wrap-around:
  - Hex: up from all-F to 0; down from 0 to all-F.
  - BCD: up from all-9 to 0; down from 0 to all-9.
  - wrap pulses in the same cycle q takes the wrapped value. Loads never assert wrap.
- bcd switched while q holds a non-BCD value: the next BCD step first clamps each nibble >9 to 9, then steps.
- Direction:
  - choose_p toggles dir one cycle after the pulse.
  - A count_tick in the same cycle as choose_p uses the old dir.
- Scan:
  - Digit index increments on scan_tick, wrapping DIGITS-1 to 0.
  - scan and seg are registered, updated the cycle after the index changes (1-cycle latency).
  - scan[i]=0 only for the active index.
  - seg decodes nibble q[4i+3:4i]. Patterns: 0=1000000, 1=1111001, 9=0010000, A=0001000, F=0001110.
  - Until the first scan_tick after reset, scan stays all ones.
- Reset mid-operation: all state returns to reset values immediately. Counting resumes from 0, direction up, after clr_n rises.

Decomposition:
- Shared package counter_scan_pkg:
  - seven-segment pattern constants SEG_0..SEG_F and SEG_BLANK
  - direction constants DIR_UP=0, DIR_DOWN=1
  - a BCD-clamp function
- One sub-module, tick_gen (parameter DIV, ports clk, clr_n, clear, tick). Instantiated twice, for the count and scan prescalers.
- Digit step logic and the seven-segment decoder stay inline.

Test Plan (DIGITS=4, COUNT_DIV=4, SCAN_DIV=2):
- Reset, enable=1, bcd=0, 20 cycles:
  - q counts 0,1,2,... every 4 clk after the synchroniser delay.
  - scan cycles 1110→1101→1011→0111 every 2 clk.
  - seg for digit 0 tracks the low nibble.
- Load data=16'h12AB, bcd=1: q=16'h1299 the cycle after load_p. The next increment gives 16'h1300 and wrap stays 0.
- Load data=16'h9999, bcd=1, up: one tick gives q=0 with wrap high for exactly 1 cycle. Toggle choose, then the next tick gives q=16'h9999 with wrap pulsed.
- Hex mode, load 16'h0000, dir down: one tick gives q=16'hFFFF with wrap pulsed. Set enable=0: q holds for 40 cycles.
- choose edge coinciding with count_tick, q=5 up: that tick gives q=6. dir flips 1 cycle later and the next tick gives q=5. load held high for many cycles loads only once.
- Assert clr_n=0 mid-count (q=16'h0037, dir=1): immediately q=0, dir=0, scan=1111, seg=7'h7F, wrap=0.

Source files
------------

// File: rtl/counter_scan_pkg.sv
// Shared constants and helpers for the counter / seven-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package counter_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        if (nib > 4'd9) begin
            return 4'd9;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/counter_scan_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
// A synchronous clear restarts the period from zero.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Prescaler counter: wraps at DIV-1, cleared on request.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/counter_scan_ctrl.sv
// Loadable up/down hex/BCD counter with a multiplexed seven-segment scan driver.
// All timing derives from clock-enable ticks; there are no derived clocks.
module counter_scan_ctrl
    import counter_scan_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int COUNT_DIV = 100_000_000,
    parameter int SCAN_DIV  = 100_000
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic                  choose,
    input  logic                  enable,
    input  logic                  bcd,
    output logic [4*DIGITS-1:0]   q,
    output logic                  dir,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     scan
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            4'hF: return SEG_F;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Synchroniser bit order: {bcd, enable, choose, load}
    logic [3:0]        sync1_r, sync2_r;
    logic              load_d_r, choose_d_r;
    logic              load_p_s, choose_p_s, enable_s, bcd_s;
    logic              count_tick_s, scan_tick_s;
    logic [W-1:0]      q_r, loaded_s, step_next_s;
    logic              step_wrap_s, carry_v, dir_r, wrap_r, started_r;
    logic [3:0]        nib_v;
    logic [IW-1:0]     idx_r;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] scan_r;

    // Two-flop synchronisers plus edge-detect history for load and choose.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_r    <= 4'b0000;
            sync2_r    <= 4'b0000;
            load_d_r   <= 1'b0;
            choose_d_r <= 1'b0;
        end else begin
            sync1_r    <= {bcd, enable, choose, load};
            sync2_r    <= sync1_r;
            load_d_r   <= sync2_r[0];
            choose_d_r <= sync2_r[1];
        end
    end

    assign load_p_s   = sync2_r[0] & ~load_d_r;
    assign choose_p_s = sync2_r[1] & ~choose_d_r;
    assign enable_s   = sync2_r[2];
    assign bcd_s      = sync2_r[3];

    tick_gen #(.DIV(COUNT_DIV)) u_count_tick (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (load_p_s),
        .tick  (count_tick_s)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (1'b0),
        .tick  (scan_tick_s)
    );

    // Load value and next step value; BCD steps clamp stray hex digits first.
    always_comb begin
        loaded_s    = data;
        step_next_s = '0;
        step_wrap_s = 1'b0;
        carry_v     = 1'b1;
        nib_v       = 4'h0;
        if (bcd_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                loaded_s[4*i +: 4] = bcd_clamp(data[4*i +: 4]);
            end
        end else begin
            loaded_s = data;
        end
        if (bcd_s) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib_v = bcd_clamp(q_r[4*i +: 4]);
                if (!carry_v) begin
                    step_next_s[4*i +: 4] = nib_v;
                end else if (dir_r == DIR_UP) begin
                    if (nib_v == 4'd9) begin
                        step_next_s[4*i +: 4] = 4'd0;
                    end else begin
                        step_next_s[4*i +: 4] = nib_v + 4'd1;
                        carry_v = 1'b0;
                    end
                end else begin
                    if (nib_v == 4'd0) begin
                        step_next_s[4*i +: 4] = 4'd9;
                    end else begin
                        step_next_s[4*i +: 4] = nib_v - 4'd1;
                        carry_v = 1'b0;
                    end
                end
            end
            step_wrap_s = carry_v;
        end else if (dir_r == DIR_UP) begin
            {step_wrap_s, step_next_s} = {1'b0, q_r} + {{W{1'b0}}, 1'b1};
        end else begin
            step_next_s = q_r - {{(W-1){1'b0}}, 1'b1};
            step_wrap_s = (q_r == '0);
        end
    end

    // Count register: load beats a simultaneous tick; wrap is a one-cycle pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            dir_r  <= DIR_UP;
        end else begin
            if (load_p_s) begin
                q_r    <= loaded_s;
                wrap_r <= 1'b0;
            end else if (count_tick_s && enable_s) begin
                q_r    <= step_next_s;
                wrap_r <= step_wrap_s;
            end else begin
                wrap_r <= 1'b0;
            end
            if (choose_p_s) begin
                dir_r <= ~dir_r;
            end else begin
                dir_r <= dir_r;
            end
        end
    end

    // Digit scan: display stays dark until the first scan tick after reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            idx_r     <= '0;
            started_r <= 1'b0;
            scan_r    <= {DIGITS{1'b1}};
            seg_r     <= SEG_BLANK;
        end else begin
            if (scan_tick_s) begin
                idx_r     <= (idx_r == IW'(DIGITS - 1)) ? '0 : idx_r + IW'(1);
                started_r <= 1'b1;
            end else begin
                idx_r     <= idx_r;
                started_r <= started_r;
            end
            if (started_r) begin
                scan_r <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
                seg_r  <= seg_decode(q_r[4*idx_r +: 4]);
            end else begin
                scan_r <= {DIGITS{1'b1}};
                seg_r  <= SEG_BLANK;
            end
        end
    end

    assign q    = q_r;
    assign dir  = dir_r;
    assign wrap = wrap_r;
    assign seg  = seg_r;
    assign scan = scan_r;

endmodule

// File: tb/tb_counter_scan_ctrl.sv
// Directed self-checking bench for counter_scan_ctrl (DIGITS=4, COUNT_DIV=4, SCAN_DIV=2).
module tb_counter_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] data;
    logic        load, choose, enable, bcd;
    logic [15:0] q;
    logic        dir, wrap;
    logic [6:0]  seg;
    logic [3:0]  scan;
    int          total = 0;
    int          bad   = 0;

    counter_scan_ctrl #(.DIGITS(4), .COUNT_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .clr_n(clr_n), .data(data), .load(load), .choose(choose),
        .enable(enable), .bcd(bcd), .q(q), .dir(dir), .wrap(wrap),
        .seg(seg), .scan(scan)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and park on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_q_change(input int budget, output bit timed_out);
        logic [15:0] old;
        old = q;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (q !== old) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0; data = 16'h0000; load = 1'b0; choose = 1'b0;
        enable = 1'b1; bcd = 1'b0;
        step(2);
        total++; if (q !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h want=0000", q); end
        total++; if (dir !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL reset_dir_wrap got=%b%b want=00", dir, wrap); end
        total++; if (scan !== 4'hF || seg !== 7'h7F) begin bad++; $display("FAIL reset_display got=%h/%h want=F/7f", scan, seg); end
    endtask

    task automatic test_count_scan();
        clr_n = 1'b1;
        step(2);
        total++; if (scan !== 4'hF) begin bad++; $display("FAIL scan_before_tick got=%b want=1111", scan); end
        step(1);
        total++; if (scan !== 4'b1101) begin bad++; $display("FAIL scan_idx1 got=%b want=1101", scan); end
        step(2);
        total++; if (scan !== 4'b1011) begin bad++; $display("FAIL scan_idx2 got=%b want=1011", scan); end
        step(2);
        total++; if (scan !== 4'b0111 || q !== 16'h0001) begin bad++; $display("FAIL scan_idx3 got=%b q=%h want=0111 q=0001", scan, q); end
        step(2);
        total++; if (scan !== 4'b1110 || seg !== 7'h24 || q !== 16'h0002) begin bad++; $display("FAIL digit0_seg2 got=%b/%h q=%h want=1110/24 q=0002", scan, seg, q); end
        step(8);
        total++; if (scan !== 4'b1110 || seg !== 7'h19 || q !== 16'h0004) begin bad++; $display("FAIL digit0_seg4 got=%b/%h q=%h want=1110/19 q=0004", scan, seg, q); end
        step(3);
        total++; if (q !== 16'h0005) begin bad++; $display("FAIL count_20 got=%h want=0005", q); end
    endtask

    task automatic test_load_bcd();
        bcd = 1'b1; data = 16'h12AB; load = 1'b1;
        step(3);
        total++; if (q !== 16'h1299 || wrap !== 1'b0) begin bad++; $display("FAIL bcd_clamp_load got=%h w=%b want=1299 w=0", q, wrap); end
        load = 1'b0;
        step(4);
        total++; if (q !== 16'h1300 || wrap !== 1'b0) begin bad++; $display("FAIL bcd_carry got=%h w=%b want=1300 w=0", q, wrap); end
    endtask

    task automatic test_bcd_wrap();
        bit to;
        data = 16'h9999; load = 1'b1;
        step(3);
        total++; if (q !== 16'h9999) begin bad++; $display("FAIL bcd_load9999 got=%h want=9999", q); end
        load = 1'b0;
        step(4);
        total++; if (q !== 16'h0000 || wrap !== 1'b1) begin bad++; $display("FAIL bcd_wrap_up got=%h w=%b want=0000 w=1", q, wrap); end
        enable = 1'b0; choose = 1'b1;
        step(1);
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle got=%b want=0", wrap); end
        step(3);
        total++; if (dir !== 1'b1 || q !== 16'h0000) begin bad++; $display("FAIL choose_toggle got=%b q=%h want=1 q=0000", dir, q); end
        choose = 1'b0; enable = 1'b1;
        wait_q_change(20, to);
        total++; if (to || q !== 16'h9999 || wrap !== 1'b1) begin bad++; $display("FAIL bcd_wrap_down got=%h w=%b timeout=%b want=9999 w=1", q, wrap, to); end
    endtask

    task automatic test_hex_down();
        bit to;
        bcd = 1'b0; data = 16'h0000; load = 1'b1;
        step(3);
        total++; if (q !== 16'h0000 || wrap !== 1'b0) begin bad++; $display("FAIL hex_load0 got=%h w=%b want=0000 w=0", q, wrap); end
        load = 1'b0;
        wait_q_change(20, to);
        total++; if (to || q !== 16'hFFFF || wrap !== 1'b1) begin bad++; $display("FAIL hex_wrap_down got=%h w=%b timeout=%b want=FFFF w=1", q, wrap, to); end
        step(1);
        enable = 1'b0;
        step(40);
        total++; if (q !== 16'hFFFF || wrap !== 1'b0) begin bad++; $display("FAIL enable_hold got=%h w=%b want=FFFF w=0", q, wrap); end
    endtask

    task automatic test_choose_tick();
        choose = 1'b1;
        step(4);
        choose = 1'b0;
        step(3);
        total++; if (dir !== 1'b0) begin bad++; $display("FAIL dir_back_up got=%b want=0", dir); end
        data = 16'h0005; load = 1'b1; enable = 1'b1;
        step(3);
        total++; if (q !== 16'h0005) begin bad++; $display("FAIL load5 got=%h want=0005", q); end
        load = 1'b0;
        step(1);
        choose = 1'b1;
        step(3);
        total++; if (q !== 16'h0006 || dir !== 1'b1) begin bad++; $display("FAIL choose_with_tick got=%h d=%b want=0006 d=1", q, dir); end
        choose = 1'b0;
        step(4);
        total++; if (q !== 16'h0005 || dir !== 1'b1) begin bad++; $display("FAIL after_choose_tick got=%h d=%b want=0005 d=1", q, dir); end
    endtask

    task automatic test_load_held();
        data = 16'h0100; load = 1'b1;
        step(20);
        total++; if (q !== 16'h00FC) begin bad++; $display("FAIL load_held_once got=%h want=00FC", q); end
        load = 1'b0;
        step(4);
    endtask

    task automatic test_reset_mid();
        data = 16'h0037; load = 1'b1;
        step(3);
        total++; if (q !== 16'h0037 || dir !== 1'b1) begin bad++; $display("FAIL pre_reset got=%h d=%b want=0037 d=1", q, dir); end
        load = 1'b0;
        clr_n = 1'b0;
        #1;
        total++; if (q !== 16'h0000 || dir !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL async_reset_cnt got=%h d=%b w=%b want=0000 d=0 w=0", q, dir, wrap); end
        total++; if (scan !== 4'hF || seg !== 7'h7F) begin bad++; $display("FAIL async_reset_disp got=%h/%h want=F/7f", scan, seg); end
        @(negedge clk);
        clr_n = 1'b1;
        step(7);
        total++; if (q !== 16'h0001 || dir !== 1'b0) begin bad++; $display("FAIL resume_after_reset got=%h d=%b want=0001 d=0", q, dir); end
    endtask

    initial begin
        test_reset();
        test_count_scan();
        test_load_bcd();
        test_bcd_wrap();
        test_hex_down();
        test_choose_tick();
        test_load_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
